// File: rtl/usb_pkg.sv
// Shared USB mux definitions: transaction type codes, per-type transfer sizes,
// status packet magic word and responder states.
package usb_pkg;

  typedef enum logic [2:0] {
    TT_NONE = 3'd0,
    TT_CODE = 3'd1,
    TT_V    = 3'd2,
    TT_KEY  = 3'd3,
    TT_SR   = 3'd5,
    TT_SL   = 3'd6
  } trans_type_e;

  // Transfer sizes in 32-bit words
  localparam int unsigned CODE_SIZE = 32'h0040_0000;
  localparam int unsigned V_SIZE    = 32'h0000_8000;
  localparam int unsigned SL_SIZE   = 4;
  localparam int unsigned SR_SIZE   = 4;
  localparam int unsigned KEY_SIZE  = 8;

  localparam logic [31:0] STATUS_MAGIC = 32'h4742_4153;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ
  } state_e;

  function automatic int unsigned type_size(input logic [2:0] t);
    case (t)
      TT_CODE: return CODE_SIZE;
      TT_V:    return V_SIZE;
      TT_SL:   return SL_SIZE;
      TT_SR:   return SR_SIZE;
      TT_KEY:  return KEY_SIZE;
      default: return 1;
    endcase
  endfunction

  function automatic logic is_write_type(input logic [2:0] t);
    return (t == TT_CODE) || (t == TT_V) || (t == TT_SL) || (t == TT_SR);
  endfunction

endpackage

// File: rtl/usb_mux_responder_if.sv
// Fabric side of the FX3/GPIF2 mux link: the bridge drives type/strobes,
// the responder answers with ready/valid and read data.
interface mux_usb_interface;
  logic [2:0]  usb_trans_type;
  logic        usb_wr;
  logic [31:0] usb_wr_data;
  logic        usb_wr_ready;
  logic        usb_rd;
  logic        usb_rd_ready;
  logic        usb_rd_valid;
  logic [31:0] usb_rd_data;

  modport bridge (
    output usb_trans_type, usb_wr, usb_wr_data, usb_rd,
    input  usb_wr_ready, usb_rd_ready, usb_rd_valid, usb_rd_data
  );

  modport mux (
    input  usb_trans_type, usb_wr, usb_wr_data, usb_rd,
    output usb_wr_ready, usb_rd_ready, usb_rd_valid, usb_rd_data
  );
endinterface

// File: rtl/usb_wr_skid.sv
// One-entry skid buffer with valid/ready on both sides; accepts a new entry
// in the same cycle the held one is popped.
module usb_wr_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         full;
  logic [W-1:0] data_q;

  assign in_ready  = ~full | out_ready;
  assign out_valid = full;
  assign out_data  = data_q;

  // NOTE: sequential state is written with <= only, so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full   <= 1'b0;
      // NOTE: the data register is reset too, because it is visible on the
      // memory port and must read as zero out of reset.
      data_q <= '0;
    end else if (in_valid && in_ready) begin
      full   <= 1'b1;
      data_q <= in_data;
    end else if (out_ready) begin
      full   <= 1'b0;
    end
  end

endmodule

// File: rtl/usb_mux_responder.sv
// Fabric-side responder: steers USB write streams to a word-addressed memory
// port and serves the 8-word key/status packet from a snapshot.
module usb_mux_responder
  import usb_pkg::*;
#(
  parameter int                ADDR_W     = 24,
  parameter logic [ADDR_W-1:0] CODE_BASE  = 24'h000000,
  parameter logic [ADDR_W-1:0] VIDEO_BASE = 24'h400000,
  parameter logic [ADDR_W-1:0] SL_BASE    = 24'h480000,
  parameter logic [ADDR_W-1:0] SR_BASE    = 24'h480004
) (
  input  logic              clk,
  input  logic              rst_n,
  mux_usb_interface.mux     mux_usb,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [31:0]       mem_wr_data,
  output logic [2:0]        mem_wr_tgt,
  input  logic              mem_wr_ready,
  input  logic [9:0]        key_state,
  input  logic [31:0]       frame_count,
  input  logic [31:0]       status_flags
);

  localparam int SKID_W = 3 + ADDR_W + 32;
  localparam int IDX_W  = $clog2(KEY_SIZE);

  state_e             state, state_nxt;
  logic [2:0]         prev_type, cur_type;
  logic [ADDR_W-1:0]  offset, last_off, base_addr;
  logic [IDX_W-1:0]   idx;
  logic [9:0]         snap_key;
  logic [31:0]        snap_frame, snap_status;
  logic               type_change, wr_fire, rd_fire, snap_take;
  logic               skid_in_valid, skid_in_ready;
  logic [SKID_W-1:0]  skid_out;

  assign type_change   = (mux_usb.usb_trans_type != prev_type);
  assign skid_in_valid = mux_usb.usb_wr & (state == ST_WRITE);
  assign wr_fire       = skid_in_valid & skid_in_ready;
  assign rd_fire       = mux_usb.usb_rd & (state == ST_READ);
  // Retake on entry, and on the last word so the next packet is fresh
  assign snap_take     = (type_change && (mux_usb.usb_trans_type == TT_KEY)) ||
                         (rd_fire && (idx == IDX_W'(KEY_SIZE - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_type <= TT_NONE;
    else        prev_type <= mux_usb.usb_trans_type;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    state_nxt = state;
    if (type_change) begin
      if (is_write_type(mux_usb.usb_trans_type))   state_nxt = ST_WRITE;
      else if (mux_usb.usb_trans_type == TT_KEY)   state_nxt = ST_READ;
      else                                         state_nxt = ST_IDLE;
    end
  end

  always_comb begin
    base_addr = '0;
    case (cur_type)
      TT_CODE: base_addr = CODE_BASE;
      TT_V:    base_addr = VIDEO_BASE;
      TT_SL:   base_addr = SL_BASE;
      TT_SR:   base_addr = SR_BASE;
      default: base_addr = '0;
    endcase
    last_off = ADDR_W'(type_size(cur_type) - 1);
  end

  // A type change abandons the running offset; the old type's last word may
  // still be in the skid and drains with its captured address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_type <= TT_NONE;
      offset   <= '0;
      idx      <= '0;
    end else if (type_change) begin
      cur_type <= mux_usb.usb_trans_type;
      offset   <= '0;
      idx      <= '0;
    end else begin
      if (wr_fire) offset <= (offset == last_off) ? '0 : offset + ADDR_W'(1);
      if (rd_fire) idx    <= idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_key    <= '0;
      snap_frame  <= '0;
      snap_status <= '0;
    end else if (snap_take) begin
      snap_key    <= key_state;
      snap_frame  <= frame_count;
      snap_status <= status_flags;
    end
  end

  usb_wr_skid #(.W(SKID_W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (skid_in_valid),
    .in_ready  (skid_in_ready),
    .in_data   ({cur_type, base_addr + offset, mux_usb.usb_wr_data}),
    .out_valid (mem_wr_en),
    .out_ready (mem_wr_ready),
    .out_data  (skid_out)
  );

  assign {mem_wr_tgt, mem_wr_addr, mem_wr_data} = skid_out;

  always_comb begin
    mux_usb.usb_wr_ready = 1'b0;
    mux_usb.usb_rd_ready = 1'b0;
    mux_usb.usb_rd_valid = 1'b0;
    mux_usb.usb_rd_data  = '0;
    case (state)
      ST_WRITE: mux_usb.usb_wr_ready = skid_in_ready;
      ST_READ: begin
        mux_usb.usb_rd_ready = 1'b1;
        mux_usb.usb_rd_valid = 1'b1;
        case (idx)
          IDX_W'(0): mux_usb.usb_rd_data = {22'h0, snap_key};
          IDX_W'(1): mux_usb.usb_rd_data = snap_frame;
          IDX_W'(2): mux_usb.usb_rd_data = snap_status;
          IDX_W'(7): mux_usb.usb_rd_data = STATUS_MAGIC;
          default:   mux_usb.usb_rd_data = '0;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: doc/usb_mux_responder.md
Name: usb_mux_responder

Overview:
- Fabric-side responder on mux_usb_interface; the counterpart of the FX3/GPIF2 bridge that drives usb_trans_type, usb_wr and usb_rd.
- Routes write streams (code, video frame, left/right sound) to a generic word-addressed memory write port, with per-type base addresses and frame wrap.
- Serves the 8-word key-and-status read packet from a snapshot register file.

Parameters:
- ADDR_W, 24, memory word-address width.
- CODE_BASE, 24'h000000, word base for code transfers.
- VIDEO_BASE, 24'h400000, word base for video frames.
- SL_BASE, 24'h480000, word base for left sound frames.
- SR_BASE, 24'h480004, word base for right sound frames.

Ports:
- clk  in  1  single system clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- mux_usb  modport mux  -  drives usb_wr_ready, usb_rd_ready, usb_rd_valid, usb_rd_data[31:0]; samples usb_trans_type[2:0], usb_wr, usb_wr_data[31:0], usb_rd.
- mem_wr_en  out  1  write request valid.
- mem_wr_addr  out  ADDR_W  word address.
- mem_wr_data  out  32  write data.
- mem_wr_tgt  out  3  transaction type of this word.
- mem_wr_ready  in  1  sink accepts when mem_wr_en & mem_wr_ready.
- key_state  in  10  GBA key bits, active-high pressed.
- frame_count  in  32  emulator frame counter.
- status_flags  in  32  misc status.

Behaviour:
- Reset (rst_n low, async): state IDLE; all outputs 0; offsets, skid buffer and snapshot cleared.
- Sizes are in words: CODE 0x400000, VIDEO 0x8000, SL/SR 4, KEY_AND_STATUS 8.
- Type tracking: prev_type registers usb_trans_type every cycle. A change selects the new state:
  - CODE, V, SL or SR -> WRITE, offset := 0.
  - KEY_AND_STATUS -> READ, idx := 0, snapshot taken.
  - NONE -> IDLE.
  - Any other code -> IDLE.
- A change mid-transaction abandons the old offset without error.
- WRITE:
  - 1-entry skid buffer holding {tgt, addr, data}.
  - usb_wr_ready = (state==WRITE) & (~skid_full | mem_wr_ready).
  - On usb_wr: capture {type, base+offset, usb_wr_data}.
  - offset increments; at size-1 it wraps to 0, so back-to-back same-type frames restart at base.
  - mem_wr_en = skid_full; the entry is popped on mem_wr_ready.
  - Latency usb_wr -> mem_wr_en is 1 cycle.
  - Simultaneous pop and push keeps skid_full high with the new entry.
  - A queued entry drains with its captured tgt/addr even after a type change.
- READ:
  - usb_rd_ready = usb_rd_valid = (state==READ).
  - usb_rd_data = snap[idx], where:
    - snap[0] = {22'h0, key_state}.
    - snap[1] = frame_count.
    - snap[2] = status_flags.
    - snap[3..6] = 0.
    - snap[7] = 32'h47424153.
  - Each usb_rd increments idx.
  - usb_rd at idx 7 wraps idx to 0 and retakes the snapshot in the same edge, so the next packet holds fresh values.
  - Snapshot is stable for the whole 8-word packet.
- usb_wr asserted outside WRITE or usb_rd outside READ is ignored; no state change.
- Offset arithmetic is ADDR_W bits unsigned; base+offset truncates, with no overflow check.

Decomposition:
- Package usb_pkg holds:
  - Transaction type enum (NONE 0, CODE 1, V 2, KEY 3, SR 5, SL 6).
  - Per-type size constants in words.
  - The status magic.
  - The state enum.
- Shared with the GPIF bridge so type codes and sizes live in one place.
- One sub-module, usb_wr_skid: parametrised 1-entry skid buffer with valid/ready on both sides.

Test Plan:
- Reset: hold rst_n low mid-WRITE with skid full -> mem_wr_en=0, usb_wr_ready=0, usb_rd_valid=0 immediately (async); after release, state IDLE.
- Video frame: type 2, push 0x8000 words with mem_wr_ready=1 -> addresses 0x400000..0x407FFF in order, data matches, no gaps. A second frame without a type change restarts at 0x400000.
- Backpressure: type 6, mem_wr_ready toggled 1/0 every cycle -> usb_wr_ready deasserts only while the skid is full and unaccepted; 4 words land at 0x480000..0x480003, none lost or duplicated.
- Status read: key_state=0x3FF, frame_count=0x12, type 3, 8 usb_rd -> 0x3FF, 0x12, status_flags, 0, 0, 0, 0, 0x47424153. Change key_state during the packet -> no effect until word 0 of the next packet.
- Type switch mid-stream: type 1, 10 words written, then type 2 -> the next word goes to 0x400000. The last code word still drains at 0x000009.
- Illegal type 7 or usb_wr in READ -> no mem_wr_en, usb_wr_ready=0.
